alu_share_arbiter: RTL and testbench

- Shares one tiny_4bit_alu instance between NREQ requesters using round-robin arbitration.
- Accepts ALU operations over a valid/ready handshake and registers the granted operation onto the ALU input pins.
- Tracks the fixed ALU pipeline latency with a tag shift register and routes each uo_out word back to the requester that issued it.
- Provides a lock so one requester can own the ALU register file across a multi-op sequence (e.g. REG_WRITE then REG_READ).

---
 rtl/alu_share_arbiter_if.sv | 27 ++
 rtl/alu_share_arbiter.sv | 82 ++++++++
 tb/tb_alu_share_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester handshake, response and ALU pin bundle for alu_share_arbiter
interface alu_share_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_op;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_lock;
    logic [NREQ-1:0]   resp_valid;
    logic [7:0]        resp_data;
    logic [7:0]        alu_ui_in;
    logic [7:0]        alu_uio;
    logic [7:0]        alu_uo_out;
    logic              busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_lock, alu_uo_out,
        output req_ready, resp_valid, resp_data, alu_ui_in, alu_uio, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_lock, alu_uo_out,
        input  req_ready, resp_valid, resp_data, alu_ui_in, alu_uio, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one pipelined 4-bit ALU with lock and tagged response routing
module alu_share_arbiter #(
    parameter int         NREQ    = 2,
    parameter int         ALU_LAT = 2,
    parameter logic [3:0] NOP_OP  = 4'hF
) (
    input logic              clk,
    input logic              rst_n,
    alu_share_arbiter_if.slave bus
);
    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    // issue register stage followed by ALU_LAT+1 stages tracking the ALU pipeline
    localparam int DEPTH = ALU_LAT + 2;

    logic [IW-1:0]             r_ptr;
    logic [IW-1:0]             r_owner;
    logic                      r_lock;
    logic [7:0]                r_ui;
    logic [7:0]                r_uio;
    logic [DEPTH-1:0]          r_tag_v;
    logic [DEPTH-1:0][IW-1:0]  r_tag_id;
    logic                      w_acc;
    logic [IW-1:0]             w_gnt;
    logic [3:0]                w_op;
    logic [3:0]                w_a;
    logic [3:0]                w_b;

    always_comb begin
        w_acc = 1'b0;
        w_gnt = r_ptr;
        if (r_lock) begin
            w_acc = bus.req_valid[r_owner];
            w_gnt = r_owner;
        end else begin
            // descending scan so the requester closest to the pointer wins
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
                    w_acc = 1'b1;
                    w_gnt = IW'((int'(r_ptr) + k) % NREQ);
                end
            end
        end
        w_op = bus.req_op[4*int'(w_gnt) +: 4];
        w_a  = bus.req_a[4*int'(w_gnt) +: 4];
        w_b  = bus.req_b[4*int'(w_gnt) +: 4];
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_acc) bus.req_ready[w_gnt] = 1'b1;
        bus.resp_valid = '0;
        if (r_tag_v[DEPTH-1]) bus.resp_valid[r_tag_id[DEPTH-1]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ui    <= '0;
            r_uio   <= {4'b0, NOP_OP};
            r_tag_v <= '0;
            r_ptr   <= '0;
            r_lock  <= 1'b0;
            r_owner <= '0;
        end else begin
            r_ui    <= w_acc ? {w_b, w_a} : 8'h00;
            r_uio   <= {4'b0, w_acc ? w_op : NOP_OP};
            r_tag_v <= {r_tag_v[DEPTH-2:0], w_acc};
            if (w_acc) begin
                r_ptr   <= (w_gnt == IW'(NREQ - 1)) ? '0 : w_gnt + IW'(1);
                r_lock  <= bus.req_lock[w_gnt];
                r_owner <= w_gnt;
            end
        end
    end

    // ids are only meaningful alongside their valid bit, so they need no reset
    always_ff @(posedge clk) r_tag_id <= {r_tag_id[DEPTH-2:0], w_gnt};

    assign bus.resp_data = bus.alu_uo_out;
    assign bus.alu_ui_in = r_ui;
    assign bus.alu_uio   = r_uio;
    assign bus.busy      = (|r_tag_v) | r_lock;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table-driven and random checks of alu_share_arbiter against a queue-based reference model
module tb_alu_share_arbiter;
    localparam int NREQ    = 2;
    localparam int ALU_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NREQ(NREQ)) bus ();
    alu_share_arbiter #(.NREQ(NREQ), .ALU_LAT(ALU_LAT), .NOP_OP(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic [3:0] rv);
        logic [4:0] s;
        logic [3:0] r;
        logic       v;
        case (op)
            4'h0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                v = (a[3] == b[3]) && (r[3] != a[3]);
                return {r == 4'd0, r[3], v, s[4], r};
            end
            4'h1: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[3:0];
                v = (a[3] != b[3]) && (r[3] != a[3]);
                return {r == 4'd0, r[3], v, s[4], r};
            end
            4'h9: return {4'h0, rv};
            4'hC, 4'hD, 4'hE: return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    // stand-in ALU: capture, result/flag register, output register
    logic [7:0] cap_ui = '0;
    logic [3:0] cap_op = 4'hF;
    logic [7:0] res    = '0;
    logic [3:0] arf [16] = '{default: '0};
    always @(posedge clk) begin
        cap_ui <= bus.alu_ui_in;
        cap_op <= bus.alu_uio[3:0];
        res    <= alu_fn(cap_op, cap_ui[3:0], cap_ui[7:4], arf[cap_ui[7:4]]);
        if (cap_op == 4'h8) arf[cap_ui[7:4]] <= cap_ui[3:0];
        bus.alu_uo_out <= res;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int id; logic [7:0] data; int due; } exp_t;
    typedef struct {
        logic [1:0] v, lk, rdy;
        logic [3:0] op0, a0, b0, op1, a1, b1;
        logic [7:0] rd;
    } vec_t;

    exp_t       q[$];
    int         ptr = 0, owner = 0;
    bit         lock = 0;
    logic [3:0] rrf [16] = '{default: '0};
    logic [7:0] exp_uio = 8'h0F, exp_ui = 8'h00;
    int         n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int exp_grant(input logic [NREQ-1:0] v);
        if (lock) return v[owner] ? owner : -1;
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic check_outputs();
        logic [NREQ-1:0] erv;
        erv = '0;
        chk("busy", bus.busy, lock || q.size() > 0);
        if (q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].id] = 1'b1;
            chk("resp_data", bus.resp_data, q[0].data);
            void'(q.pop_front());
        end else if (q.size() > 0 && q[0].due < cyc) begin
            void'(q.pop_front());
        end
        chk("resp_valid", bus.resp_valid, erv);
        chk("alu_uio", bus.alu_uio, exp_uio);
        chk("alu_ui_in", bus.alu_ui_in, exp_ui);
    endtask

    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] lk,
                         input logic [4*NREQ-1:0] op, input logic [4*NREQ-1:0] a,
                         input logic [4*NREQ-1:0] b, input bit use_tbl,
                         input logic [NREQ-1:0] trdy, input logic [7:0] trd);
        int g;
        logic [NREQ-1:0] erdy;
        logic [3:0] go, ga, gb;
        logic [7:0] w;
        check_outputs();
        bus.req_valid = v;
        bus.req_lock  = lk;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        #1;
        g = exp_grant(v);
        erdy = '0;
        if (g >= 0) erdy[g] = 1'b1;
        chk("req_ready", bus.req_ready, erdy);
        if (use_tbl) chk("req_ready_tbl", bus.req_ready, trdy);
        if (g >= 0) begin
            go = op[4*g +: 4];
            ga = a[4*g +: 4];
            gb = b[4*g +: 4];
            w = use_tbl ? trd : alu_fn(go, ga, gb, rrf[gb]);
            if (go == 4'h8) rrf[gb] = ga;
            q.push_back('{id: g, data: w, due: cyc + ALU_LAT + 2});
            ptr     = (g + 1) % NREQ;
            lock    = lk[g];
            owner   = g;
            exp_uio = {4'b0, go};
            exp_ui  = {gb, ga};
        end else begin
            exp_uio = 8'h0F;
            exp_ui  = 8'h00;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] lk, input logic [1:0] rdy,
                                input logic [3:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                                input logic [3:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                                input logic [7:0] rd);
        return '{v: v, lk: lk, rdy: rdy, op0: op0, a0: a0, b0: b0, op1: op1, a1: a1, b1: b1, rd: rd};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '1, '0, '0, 1'b0, '0, 8'h00);
    endtask

    logic [3:0] ops [7] = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE};
    vec_t tbl[$];

    initial begin
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_op    = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;

        tbl.push_back(mk(2'b01, 2'b00, 2'b01, 4'h0, 4'd3, 4'd4, 4'hF, 4'd0, 4'd0, 8'h07));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(2'b00, 2'b00, 2'b00, 4'hF, 4'd0, 4'd0, 4'hF, 4'd0, 4'd0, 8'h00));
        tbl.push_back(mk(2'b10, 2'b00, 2'b10, 4'hF, 4'd0, 4'd0, 4'h0, 4'd7, 4'd1, 8'h68));
        tbl.push_back(mk(2'b01, 2'b00, 2'b01, 4'h1, 4'd3, 4'd3, 4'hF, 4'd0, 4'd0, 8'h80));
        tbl.push_back(mk(2'b10, 2'b00, 2'b10, 4'hF, 4'd0, 4'd0, 4'h0, 4'd1, 4'd1, 8'h02));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(2'b11, 2'b00, (i % 2) ? 2'b10 : 2'b01, 4'h0, 4'd1, 4'd2,
                             4'h1, 4'd5, 4'd3, (i % 2) ? 8'h02 : 8'h03));
        tbl.push_back(mk(2'b11, 2'b01, 2'b01, 4'h8, 4'd5, 4'd2, 4'h0, 4'd1, 4'd1, 8'h00));
        tbl.push_back(mk(2'b11, 2'b00, 2'b01, 4'h9, 4'd0, 4'd2, 4'h0, 4'd1, 4'd1, 8'h05));
        tbl.push_back(mk(2'b11, 2'b00, 2'b10, 4'h0, 4'd1, 4'd2, 4'h0, 4'd1, 4'd1, 8'h02));
        tbl.push_back(mk(2'b11, 2'b01, 2'b01, 4'h0, 4'd0, 4'd0, 4'h0, 4'd1, 4'd1, 8'h80));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(2'b10, 2'b00, 2'b00, 4'hF, 4'd0, 4'd0, 4'h0, 4'd1, 4'd1, 8'h00));
        tbl.push_back(mk(2'b11, 2'b00, 2'b01, 4'h0, 4'd1, 4'd2, 4'h0, 4'd1, 4'd1, 8'h03));
        tbl.push_back(mk(2'b10, 2'b00, 2'b10, 4'hF, 4'd0, 4'd0, 4'h0, 4'd1, 4'd1, 8'h02));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(2'b00, 2'b00, 2'b00, 4'hF, 4'd0, 4'd0, 4'hF, 4'd0, 4'd0, 8'h00));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", bus.resp_valid, '0);
        chk("rst_alu_uio", bus.alu_uio, 8'h0F);
        chk("rst_alu_ui_in", bus.alu_ui_in, 8'h00);
        chk("rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i])
            cycle(tbl[i].v, tbl[i].lk, {tbl[i].op1, tbl[i].op0}, {tbl[i].a1, tbl[i].a0},
                  {tbl[i].b1, tbl[i].b0}, 1'b1, tbl[i].rdy, tbl[i].rd);

        // reset one cycle after a locked accept drops the op and the lock
        cycle(2'b10, 2'b10, {4'h0, 4'hF}, {4'd2, 4'd0}, {4'd2, 4'd0}, 1'b1, 2'b10, 8'h04);
        check_outputs();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        q.delete();
        lock = 0; ptr = 0; owner = 0;
        exp_uio = 8'h0F;
        exp_ui  = 8'h00;
        chk("mid_rst_resp_valid", bus.resp_valid, '0);
        chk("mid_rst_alu_uio", bus.alu_uio, 8'h0F);
        chk("mid_rst_busy", bus.busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("in_rst_resp_valid", bus.resp_valid, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(2'b11, 2'b00, {4'h0, 4'h0}, {4'd1, 4'd2}, {4'd1, 4'd2}, 1'b1, 2'b01, 8'h04);
        idle(5);

        for (int i = 0; i < 400; i++) begin
            logic [4*NREQ-1:0] op, a, b;
            logic [NREQ-1:0] lk;
            for (int r = 0; r < NREQ; r++) begin
                op[4*r +: 4] = ops[$urandom_range(6)];
                a[4*r +: 4]  = 4'($urandom);
                b[4*r +: 4]  = 4'($urandom);
                lk[r]        = ($urandom_range(3) == 0);
            end
            cycle(NREQ'($urandom), lk, op, a, b, 1'b0, '0, 8'h00);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
